// File: rtl/scatter_pkg.sv
// Shared types and helpers for the scatter sequencer.
// Column tables are zero-extended to MAX_COLS bits before use.
package scatter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } scatter_state_t;

   localparam int MAX_COLS = 64;

   typedef logic [MAX_COLS-1:0] ind_tbl_t;

   // Number of columns flagged as large.
   function automatic int popcount_ind(ind_tbl_t tbl);
      int n;
      n = 0;
      for (int i = 0; i < MAX_COLS; i++) begin
         if (tbl[i]) n++;
      end
      return n;
   endfunction

   // Position of column c inside its own (large or small) group.
   function automatic int col_rank(ind_tbl_t tbl, int c);
      int k;
      k = 0;
      for (int i = 0; i < MAX_COLS; i++) begin
         if (i < c && tbl[i] == tbl[c]) k++;
      end
      return k;
   endfunction

endpackage

// File: rtl/scatter_out_reg.sv
// One-entry valid/ready output register with data and last flag.
// free_o says the slot can take a new beat this cycle.
module scatter_out_reg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         last_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic         last_o,
   output logic         free_o
);

   logic         valid_q;
   logic [W-1:0] data_q;
   logic         last_q;

   assign free_o  = !valid_q || ready_i;
   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = last_q;

   // Load on accept, otherwise retire the held beat once it is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         last_q  <= last_i;
         data_q  <= data_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end
   end

endmodule

// File: rtl/scatter_sequencer.sv
// Streams one tensor, splitting each row's columns into a
// large stream and a small stream under a validated table.
module scatter_sequencer
   import scatter_pkg::*;
#(
   parameter int IN_WIDTH          = 16,
   parameter int IN_SIZE           = 4,
   parameter int IN_PARALLELISM    = 1,
   parameter int OUT_LARGE_COLUMNS = 2,
   parameter int OUT_SMALL_COLUMNS = IN_SIZE - OUT_LARGE_COLUMNS,
   parameter int DEPTH             = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic [IN_SIZE-1:0] cfg_ind_table,
   input  logic cfg_valid,
   output logic cfg_ready,
   output logic cfg_error,
   input  logic [IN_WIDTH*IN_SIZE*IN_PARALLELISM-1:0] data_in,
   input  logic data_in_valid,
   output logic data_in_ready,
   output logic [IN_WIDTH*OUT_LARGE_COLUMNS*IN_PARALLELISM-1:0] data_out_large,
   output logic data_out_large_valid,
   input  logic data_out_large_ready,
   output logic data_out_large_last,
   output logic [IN_WIDTH*OUT_SMALL_COLUMNS*IN_PARALLELISM-1:0] data_out_small,
   output logic data_out_small_valid,
   input  logic data_out_small_ready,
   output logic data_out_small_last,
   output logic busy,
   output logic done
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int LW = IN_WIDTH * OUT_LARGE_COLUMNS * IN_PARALLELISM;
   localparam int SW = IN_WIDTH * OUT_SMALL_COLUMNS * IN_PARALLELISM;

   scatter_state_t state_q, state_d;
   logic [IN_SIZE-1:0] tbl_q, tbl_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic               done_q, done_d;

   logic          free_l, free_s;
   logic          accept, last_beat, cfg_ok;
   logic [LW-1:0] scat_large;
   logic [SW-1:0] scat_small;

   assign cfg_ready     = (state_q == IDLE) && !rst;
   assign data_in_ready = (state_q == RUN) && free_l && free_s;
   assign accept        = data_in_valid && data_in_ready;
   assign last_beat     = cnt_q == CNT_W'(DEPTH - 1);
   assign cfg_ok        = popcount_ind(ind_tbl_t'(cfg_ind_table))
                          == OUT_LARGE_COLUMNS;
   assign busy          = state_q != IDLE;
   assign done          = done_q;
   assign cfg_error     = err_q;

   // Route every column of every row to its compacted lane slot.
   always_comb begin
      int rk;
      rk         = 0;
      scat_large = '0;
      scat_small = '0;
      for (int r = 0; r < IN_PARALLELISM; r++) begin
         for (int c = 0; c < IN_SIZE; c++) begin
            rk = col_rank(ind_tbl_t'(tbl_q), c);
            if (tbl_q[c]) begin
               if (rk < OUT_LARGE_COLUMNS)
                  scat_large[(r*OUT_LARGE_COLUMNS+rk)*IN_WIDTH +: IN_WIDTH] =
                     data_in[(r*IN_SIZE+c)*IN_WIDTH +: IN_WIDTH];
            end else begin
               if (rk < OUT_SMALL_COLUMNS)
                  scat_small[(r*OUT_SMALL_COLUMNS+rk)*IN_WIDTH +: IN_WIDTH] =
                     data_in[(r*IN_SIZE+c)*IN_WIDTH +: IN_WIDTH];
            end
         end
      end
   end

   // Sequencer next state: config, beat counting and drain.
   always_comb begin
      state_d = state_q;
      tbl_d   = tbl_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cfg_valid) begin
               if (cfg_ok) begin
                  state_d = RUN;
                  tbl_d   = cfg_ind_table;
                  err_d   = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (accept) begin
               if (last_beat) begin
                  cnt_d   = '0;
                  state_d = DRAIN;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         DRAIN: begin
            if (free_l && free_s) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         tbl_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tbl_q   <= tbl_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   scatter_out_reg #(.W(LW)) u_large (
      .clk     (clk),
      .rst     (rst),
      .load_i  (accept),
      .data_i  (scat_large),
      .last_i  (last_beat),
      .ready_i (data_out_large_ready),
      .valid_o (data_out_large_valid),
      .data_o  (data_out_large),
      .last_o  (data_out_large_last),
      .free_o  (free_l)
   );

   scatter_out_reg #(.W(SW)) u_small (
      .clk     (clk),
      .rst     (rst),
      .load_i  (accept),
      .data_i  (scat_small),
      .last_i  (last_beat),
      .ready_i (data_out_small_ready),
      .valid_o (data_out_small_valid),
      .data_o  (data_out_small),
      .last_o  (data_out_small_last),
      .free_o  (free_s)
   );

endmodule

// File: tb/tb_scatter_sequencer.sv
// Directed bench for scatter_sequencer: single-row and
// two-row instances, hand-computed expected values.
module tb_scatter_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [3:0]  cfg_tbl;
   logic        cfg_valid, cfg_ready, cfg_error;
   logic [63:0] din;
   logic        din_valid, din_ready;
   logic [31:0] lo, so;
   logic        lv, lr, ll, sv, sr, sl, busy, done;

   logic [3:0]   p_cfg_tbl;
   logic         p_cfg_valid, p_cfg_ready, p_cfg_error;
   logic [127:0] p_din;
   logic         p_din_valid, p_din_ready;
   logic [63:0]  p_lo, p_so;
   logic         p_lv, p_ll, p_sv, p_sl, p_busy, p_done;
   logic         p_lr, p_sr;

   scatter_sequencer #(
      .IN_WIDTH(16), .IN_SIZE(4), .IN_PARALLELISM(1),
      .OUT_LARGE_COLUMNS(2), .DEPTH(3)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_ind_table(cfg_tbl), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .cfg_error(cfg_error),
      .data_in(din), .data_in_valid(din_valid),
      .data_in_ready(din_ready),
      .data_out_large(lo), .data_out_large_valid(lv),
      .data_out_large_ready(lr), .data_out_large_last(ll),
      .data_out_small(so), .data_out_small_valid(sv),
      .data_out_small_ready(sr), .data_out_small_last(sl),
      .busy(busy), .done(done)
   );

   scatter_sequencer #(
      .IN_WIDTH(16), .IN_SIZE(4), .IN_PARALLELISM(2),
      .OUT_LARGE_COLUMNS(2), .DEPTH(3)
   ) dut_p (
      .clk(clk), .rst(rst),
      .cfg_ind_table(p_cfg_tbl), .cfg_valid(p_cfg_valid),
      .cfg_ready(p_cfg_ready), .cfg_error(p_cfg_error),
      .data_in(p_din), .data_in_valid(p_din_valid),
      .data_in_ready(p_din_ready),
      .data_out_large(p_lo), .data_out_large_valid(p_lv),
      .data_out_large_ready(p_lr), .data_out_large_last(p_ll),
      .data_out_small(p_so), .data_out_small_valid(p_sv),
      .data_out_small_ready(p_sr), .data_out_small_last(p_sl),
      .busy(p_busy), .done(p_done)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int l_hs   = 0;
   int s_hs   = 0;
   int s0;

   always @(posedge clk) begin
      if (!rst && lv && lr) l_hs++;
      if (!rst && sv && sr) s_hs++;
   end

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      cfg_tbl = 4'b0; cfg_valid = 1'b0;
      din = '0; din_valid = 1'b0; lr = 1'b1; sr = 1'b1;
      p_cfg_tbl = 4'b0; p_cfg_valid = 1'b0;
      p_din = '0; p_din_valid = 1'b0; p_lr = 1'b1; p_sr = 1'b1;
      tick();
      tick();

      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_lv", lv, 0);
      chk("rst_sv", sv, 0);
      chk("rst_last", {ll, sl}, 0);
      chk("rst_err", cfg_error, 0);
      chk("rst_done", done, 0);
      chk("rst_din_ready", din_ready, 0);
      rst = 1'b0;
      #1;
      chk("idle_cfg_ready", cfg_ready, 1);

      // bad config 1,1,1,0
      cfg_tbl = 4'b0111; cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      chk("bad_err", cfg_error, 1);
      chk("bad_busy", busy, 0);
      chk("bad_din_ready", din_ready, 0);
      chk("bad_cfg_ready", cfg_ready, 1);

      // good config 0,1,0,1
      cfg_tbl = 4'b1010; cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      chk("good_busy", busy, 1);
      chk("good_err", cfg_error, 0);
      chk("run_cfg_ready", cfg_ready, 0);
      chk("run_din_ready", din_ready, 1);

      // basic split
      din = {16'h40, 16'h30, 16'h20, 16'h10}; din_valid = 1'b1;
      tick();
      chk("b1_large", lo, {16'h40, 16'h20});
      chk("b1_small", so, {16'h30, 16'h10});
      chk("b1_valids", {lv, sv}, 2'b11);
      chk("b1_lasts", {ll, sl}, 2'b00);

      // backpressure on large
      lr = 1'b0;
      din = {16'h41, 16'h31, 16'h21, 16'h11};
      s0 = s_hs;
      #1;
      chk("bp_din_ready0", din_ready, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_din_ready", din_ready, 0);
         chk("bp_lv", lv, 1);
         chk("bp_large_hold", lo, {16'h40, 16'h20});
      end
      chk("bp_sv", sv, 0);
      chk("bp_small_taken", s_hs - s0, 1);
      lr = 1'b1;
      #1;
      chk("bp_release", din_ready, 1);
      tick();
      chk("b2_large", lo, {16'h41, 16'h21});
      chk("b2_small", so, {16'h31, 16'h11});
      chk("b2_lasts", {ll, sl}, 2'b00);

      // tensor end
      din = {16'h42, 16'h32, 16'h22, 16'h12};
      tick();
      sr = 1'b0;
      chk("b3_large", lo, {16'h42, 16'h22});
      chk("b3_small", so, {16'h32, 16'h12});
      chk("b3_lasts", {ll, sl}, 2'b11);
      chk("drain_din_ready", din_ready, 0);
      tick();
      chk("dr_lv", lv, 0);
      chk("dr_ll", ll, 0);
      chk("dr_small_hold", {sv, sl}, 2'b11);
      chk("dr_small_data", so, {16'h32, 16'h12});
      chk("dr_busy", busy, 1);
      chk("dr_done", done, 0);
      chk("dr_din_ready", din_ready, 0);
      sr = 1'b1; din_valid = 1'b0;
      tick();
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_cfg_ready", cfg_ready, 1);
      chk("end_sv", {sv, sl}, 2'b00);
      chk("sb_large_cnt", l_hs, 3);
      chk("sb_small_cnt", s_hs, 3);
      tick();
      chk("done_pulse", done, 0);

      // reset mid-run
      cfg_tbl = 4'b1010; cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      chk("r_busy", busy, 1);
      din = {16'h43, 16'h33, 16'h23, 16'h13}; din_valid = 1'b1;
      tick();
      chk("r_lv", lv, 1);
      din_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("r_valids", {lv, sv}, 2'b00);
      chk("r_idle", busy, 0);
      chk("r_cfg_ready", cfg_ready, 1);
      cfg_tbl = 4'b0011; cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      chk("r2_busy", busy, 1);
      chk("r2_err", cfg_error, 0);
      din = {16'h4, 16'h3, 16'h2, 16'h1}; din_valid = 1'b1;
      tick();
      chk("r2_b1_large", lo, {16'h2, 16'h1});
      chk("r2_b1_small", so, {16'h4, 16'h3});
      chk("r2_b1_last", {ll, sl}, 2'b00);
      din = {16'h8, 16'h7, 16'h6, 16'h5};
      cfg_tbl = 4'b1100; cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      chk("r2_b2_large", lo, {16'h6, 16'h5});
      chk("r2_b2_small", so, {16'h8, 16'h7});
      chk("r2_b2_last", {ll, sl}, 2'b00);
      din = {16'hc, 16'hb, 16'ha, 16'h9};
      tick();
      din_valid = 1'b0;
      chk("r2_b3_large", lo, {16'ha, 16'h9});
      chk("r2_b3_small", so, {16'hc, 16'hb});
      chk("r2_b3_last", {ll, sl}, 2'b11);
      tick();
      chk("r2_done", done, 1);

      // multi-row instance, table 1,0,0,1
      p_cfg_tbl = 4'b1001; p_cfg_valid = 1'b1;
      tick();
      p_cfg_valid = 1'b0;
      chk("p_busy", p_busy, 1);
      p_din = {16'h8, 16'h7, 16'h6, 16'h5,
               16'h4, 16'h3, 16'h2, 16'h1};
      p_din_valid = 1'b1;
      tick();
      p_din_valid = 1'b0;
      chk("p_large", p_lo, {16'h8, 16'h5, 16'h4, 16'h1});
      chk("p_small", p_so, {16'h7, 16'h6, 16'h3, 16'h2});
      chk("p_valids", {p_lv, p_sv}, 2'b11);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
